fetch_queue: RTL and testbench

Parametrised instruction queue between stage1_fetch and stage2_decode.
- Decouples the fetch rate from decode stalls.
- Holds up to DEPTH fetched instructions, each paired with its PC, in program order.
- A branch_taken flush from the execute stage discards all queued instructions in one cycle.
- Both sides use the fetch_to_decode valid/ready handshake. The queue replaces the single-entry fetch-to-decode register.

---
 rtl/fetch_queue_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 97 +++++++++
 tb/tb_fetch_queue.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch-to-decode instruction queue.
// The default entry layout and depth are what the cpu top uses to size its
// instance; the queue itself re-derives its entry layout from its parameters.
package fetch_queue_pkg;

    localparam int FETCH_QUEUE_DEPTH = 4;
    localparam int FQ_ADDR_WIDTH     = 32;
    localparam int FQ_DATA_WIDTH     = 32;

    typedef struct packed {
        logic [FQ_ADDR_WIDTH-1:0] pc;
        logic [FQ_DATA_WIDTH-1:0] instr;
    } fetch_queue_entry_t;

    // Pointer width: index bits plus one wrap bit to tell full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode: DEPTH entries of {pc, instr}
// held in program order, valid/ready on both sides, single-cycle flush.
// Optional macro FETCH_QUEUE_BYPASS_EN: when the queue is empty an incoming
// beat is presented on the output in the same cycle, and is not stored if
// decode takes it immediately.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH             = FETCH_QUEUE_DEPTH,
    parameter int DATA_WIDTH        = FQ_DATA_WIDTH,
    parameter int ADDR_WIDTH        = FQ_ADDR_WIDTH,
    parameter int ALMOST_FULL_LEVEL = DEPTH - 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_WIDTH-1:0]   in_pc,
    input  logic [DATA_WIDTH-1:0]   in_instr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDR_WIDTH-1:0]   out_pc,
    output logic [DATA_WIDTH-1:0]   out_instr,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    almost_full
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          write;
`ifdef FETCH_QUEUE_BYPASS_EN
    logic          bypass;
`endif

    // Status, handshake and head-of-queue output decode.
    always_comb begin
        empty       = (wr_ptr == rd_ptr);
        full        = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[IW] != rd_ptr[IW]);
        in_ready    = !full;
        head        = mem[rd_ptr[IW-1:0]];
        push        = in_valid && in_ready;
        // Only stored entries are popped; a bypassed beat never occupies a slot.
        pop         = !empty && out_ready;
        almost_full = (count >= PW'(ALMOST_FULL_LEVEL));
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass      = empty && in_valid && !flush;
        out_valid   = !empty || bypass;
        out_pc      = bypass ? in_pc    : head.pc;
        out_instr   = bypass ? in_instr : head.instr;
        write       = push && !(bypass && out_ready);
`else
        out_valid   = !empty;
        out_pc      = head.pc;
        out_instr   = head.instr;
        write       = push;
`endif
    end

    // Pointer and occupancy update; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (write) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            case ({write, pop})
                2'b10:   count <= count + PW'(1);
                2'b01:   count <= count - PW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are left unreset, only the pointers matter.
    always_ff @(posedge clk) begin
        if (write && !rst && !flush)
            mem[wr_ptr[IW-1:0]] <= entry_t'{pc: in_pc, instr: in_instr};
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, hand sequences
// for streaming/wrap and bypass, then randomized traffic against a queue model.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int AFL   = DEPTH - 1;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, out_valid, out_ready, almost_full;
    logic [AW-1:0] in_pc, out_pc;
    logic [DW-1:0] in_instr, out_instr;
    logic [2:0]    count;

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALMOST_FULL_LEVEL(AFL)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .count(count), .almost_full(almost_full)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic drive(input logic r, input logic f, input logic iv,
                         input logic [31:0] pc, input logic [31:0] ins, input logic ordy);
        rst = r; flush = f; in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy;
    endtask

    typedef struct {
        logic        rst, flush, iv;
        logic [31:0] pc;
        logic        ordy;
        logic        ov;
        logic [31:0] opc;
        logic        irdy;
        int          cnt;
        logic        af;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic f, input logic iv, input logic [31:0] pc,
                                input logic ordy, input logic ov, input logic [31:0] opc,
                                input logic irdy, input int cnt, input logic af);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.pc = pc; v.ordy = ordy;
        v.ov = ov; v.opc = opc; v.irdy = irdy; v.cnt = cnt; v.af = af;
        return v;
    endfunction

    vec_t        vecs[$];
    logic [63:0] mq[$];   // model: {pc, instr} in program order

    initial begin
        drive(1, 0, 0, 0, 0, 0);

        // Expected values describe the state after the edge, observed with idle inputs.
        vecs.push_back(mk(1,0,0,32'h0,0,   0,32'h0,1,0,0));   // reset
        vecs.push_back(mk(1,0,0,32'h0,0,   0,32'h0,1,0,0));
        vecs.push_back(mk(0,0,1,32'h0,0,   1,32'h0,1,1,0));   // fill
        vecs.push_back(mk(0,0,1,32'h4,0,   1,32'h0,1,2,0));
        vecs.push_back(mk(0,0,1,32'h8,0,   1,32'h0,1,3,1));
        vecs.push_back(mk(0,0,1,32'hC,0,   1,32'h0,0,4,1));
        vecs.push_back(mk(0,0,1,32'h10,0,  1,32'h0,0,4,1));   // 5th push refused
        vecs.push_back(mk(0,0,1,32'h10,1,  1,32'h4,1,3,1));   // full: pop only
        vecs.push_back(mk(0,0,0,32'h0,1,   1,32'h8,1,2,0));
        vecs.push_back(mk(0,0,0,32'h0,1,   1,32'hC,1,1,0));
        vecs.push_back(mk(0,0,0,32'h0,1,   0,32'h0,1,0,0));
        vecs.push_back(mk(0,0,0,32'h0,0,   0,32'h0,1,0,0));
        vecs.push_back(mk(0,0,1,32'h20,0,  1,32'h20,1,1,0));  // flush scenario
        vecs.push_back(mk(0,0,1,32'h24,0,  1,32'h20,1,2,0));
        vecs.push_back(mk(0,0,1,32'h28,0,  1,32'h20,1,3,1));
        vecs.push_back(mk(0,1,1,32'h100,1, 0,32'h0,1,0,0));
        vecs.push_back(mk(0,0,1,32'h200,0, 1,32'h200,1,1,0));
        vecs.push_back(mk(0,0,0,32'h0,1,   0,32'h0,1,0,0));
        vecs.push_back(mk(0,0,1,32'h300,0, 1,32'h300,1,1,0)); // reset mid-stream
        vecs.push_back(mk(0,0,1,32'h304,0, 1,32'h300,1,2,0));
        vecs.push_back(mk(1,0,1,32'h308,1, 0,32'h0,1,0,0));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].pc, instr_of(vecs[i].pc), vecs[i].ordy);
            @(posedge clk);
            #1 drive(0, 0, 0, 0, 0, 0);
            #1;
            check($sformatf("v%0d.out_valid", i), out_valid, vecs[i].ov);
            check($sformatf("v%0d.in_ready", i), in_ready, vecs[i].irdy);
            check($sformatf("v%0d.count", i), count, vecs[i].cnt);
            check($sformatf("v%0d.almost_full", i), almost_full, vecs[i].af);
            if (vecs[i].ov) begin
                check($sformatf("v%0d.out_pc", i), out_pc, vecs[i].opc);
                check($sformatf("v%0d.out_instr", i), out_instr, instr_of(vecs[i].opc));
            end
        end

        // Streaming with wrap: 20 back-to-back beats, decode always ready.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(0, 0, 1, 32'h1000 + 32'(4*i), instr_of(32'h1000 + 32'(4*i)), 1);
            #1;
`ifdef FETCH_QUEUE_BYPASS_EN
            check($sformatf("stream%0d.out_valid", i), out_valid, 1);
            check($sformatf("stream%0d.out_pc", i), out_pc, 32'h1000 + 32'(4*i));
            check($sformatf("stream%0d.count", i), count, 0);
`else
            if (i == 0) begin
                check("stream0.out_valid", out_valid, 0);
                check("stream0.count", count, 0);
            end else begin
                check($sformatf("stream%0d.out_valid", i), out_valid, 1);
                check($sformatf("stream%0d.out_pc", i), out_pc, 32'h1000 + 32'(4*(i-1)));
                check($sformatf("stream%0d.count", i), count, 1);
            end
`endif
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1);
        #1;
`ifndef FETCH_QUEUE_BYPASS_EN
        check("stream_tail.out_pc", out_pc, 32'h1000 + 32'(4*19));
        check("stream_tail.count", count, 1);
`endif
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check("stream_end.count", count, 0);
        check("stream_end.out_valid", out_valid, 0);

`ifdef FETCH_QUEUE_BYPASS_EN
        // Bypass corners: flush suppresses pass-through; unready decode stores the beat.
        @(negedge clk);
        drive(0, 1, 1, 32'h500, instr_of(32'h500), 1);
        #1 check("byp_flush.out_valid", out_valid, 0);
        @(negedge clk);
        drive(0, 0, 1, 32'h504, instr_of(32'h504), 1);
        #1 check("byp_pass.out_pc", out_pc, 32'h504);
        check("byp_pass.out_valid", out_valid, 1);
        check("byp_pass.count", count, 0);
        @(negedge clk);
        drive(0, 0, 1, 32'h508, instr_of(32'h508), 0);
        #1 check("byp_hold.out_pc", out_pc, 32'h508);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1 check("byp_stored.count", count, 1);
        check("byp_stored.out_pc", out_pc, 32'h508);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1 check("byp_drained.count", count, 0);
`endif

        // Randomized traffic against the queue model (model starts empty).
        mq.delete();
        for (int c = 0; c < 1500; c++) begin
            logic        r, f, iv, ordy, exp_ov, byp;
            logic [31:0] pc, ins;
            logic [63:0] hd;
            int          sz, rdy_pct;
            @(negedge clk);
            rdy_pct = ((c / 100) % 3 == 0) ? 80 : (((c / 100) % 3 == 1) ? 20 : 50);
            r    = ($urandom_range(0, 199) == 0);
            f    = ($urandom_range(0, 59) == 0);
            iv   = ($urandom_range(0, 99) < 70);
            ordy = ($urandom_range(0, 99) < rdy_pct);
            pc   = $urandom;
            ins  = $urandom;
            drive(r, f, iv, pc, ins, ordy);
            #1;
            sz     = mq.size();
            exp_ov = (sz > 0);
            hd     = (sz > 0) ? mq[0] : 64'h0;
            byp    = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
            byp = (sz == 0) && iv && !f;
            if (byp) begin
                exp_ov = 1'b1;
                hd     = {pc, ins};
            end
`endif
            check("rand.out_valid", out_valid, exp_ov);
            check("rand.in_ready", in_ready, sz < DEPTH);
            check("rand.count", count, sz);
            check("rand.almost_full", almost_full, sz >= AFL);
            if (exp_ov) check("rand.head", {out_pc, out_instr}, hd);
            if (r || f) mq.delete();
            else begin
                if (sz > 0 && ordy) void'(mq.pop_front());
                if (iv && sz < DEPTH && !(byp && ordy)) mq.push_back({pc, ins});
            end
        end

        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1 check("final.count", count, mq.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
